blueintegral_mat_factor: RTL and testbench

//  Inverse of the 2x2 binary matrix multiplier. The host loads a target product C
//  (four 2-bit entries, packed exactly as the multiplier output). The block then scans
//  all 256 binary operand pairs (A,B) sequentially. It reports the first pair with A*B==C,
//  or reports that no pair exists. Sits directly on the tile's 8-bit io_in/io_out pins.

---
 rtl/blueintegral_mat_factor.sv | 119 +++++++++++
 tb/tb_blueintegral_mat_factor.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blueintegral_mat_factor.sv
// ---------------------------------------------------------------------------
// blueintegral_mat_factor
//
// Purpose:
//   Factorises a 2x2 binary matrix product. The host loads a target product
//   T (four 2-bit entries) and issues start. The block then steps through all
//   256 binary operand pairs (A,B) in ascending order, one per cycle. It stops
//   on the first pair whose product equals T. If no pair matches, it stops
//   after the last candidate and reports that no factorisation exists.
//
// Ports (tile pin map):
//   io_in[0]    clk, rising edge
//   io_in[1]    rst_n, synchronous, active-low, overrides every command
//   io_in[3:2]  cmd: 00 nop, 01 load T[3:0], 10 load T[7:4], 11 start
//   io_in[7:4]  nibble data for load commands; io_in[4] also selects the view
//   io_out      view=1: candidate {A00,A01,A10,A11,B00,B01,B10,B11}
//               view=0: status {st[1:0], 6'b0}
// ---------------------------------------------------------------------------
module blueintegral_mat_factor (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_FOUND  = 2'b10,
        ST_NONE   = 2'b11
    } state_e;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_LOADL = 2'b01;
    localparam logic [1:0] CMD_LOADH = 2'b10;
    localparam logic [1:0] CMD_START = 2'b11;

    logic       clk;
    logic       rst_n;
    logic [1:0] cmd;
    logic [3:0] nibble;
    logic       view;

    assign clk    = io_in[0];
    assign rst_n  = io_in[1];
    assign cmd    = io_in[3:2];
    assign nibble = io_in[7:4];
    assign view   = io_in[4];

    state_e     state_q, state_d;
    logic [7:0] target_q, target_d;
    logic [7:0] cand_q, cand_d;

    // Unpack the candidate into its matrix entries.
    logic a00, a01, a10, a11;
    logic b00, b01, b10, b11;
    assign {a00, a01, a10, a11, b00, b01, b10, b11} = cand_q;

    // Each product entry is a sum of two one-bit terms, so it ranges 0..2 and
    // can never equal 3. A target holding a 3 therefore always ends in NONE.
    logic [1:0] p00, p01, p10, p11;
    logic [7:0] prod;
    assign p00  = {1'b0, a00 & b00} + {1'b0, a01 & b10};
    assign p01  = {1'b0, a00 & b01} + {1'b0, a01 & b11};
    assign p10  = {1'b0, a10 & b00} + {1'b0, a11 & b10};
    assign p11  = {1'b0, a10 & b01} + {1'b0, a11 & b11};
    assign prod = {p00, p01, p10, p11};

    // Command decode and search step. Loads and start act from any state;
    // a nop only advances the scan while searching and otherwise holds.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cand_d   = cand_q;
        unique case (cmd)
            CMD_LOADL: begin
                target_d[3:0] = nibble;
                state_d       = ST_IDLE;
            end
            CMD_LOADH: begin
                target_d[7:4] = nibble;
                state_d       = ST_IDLE;
            end
            CMD_START: begin
                cand_d  = 8'h00;
                state_d = ST_SEARCH;
            end
            CMD_NOP: begin
                if (state_q == ST_SEARCH) begin
                    if (prod == target_q) begin
                        state_d = ST_FOUND;
                    end else if (cand_q == 8'hFF) begin
                        state_d = ST_NONE;
                    end else begin
                        cand_d = cand_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over commands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            target_q <= 8'h00;
            cand_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cand_q   <= cand_d;
        end
    end

    // Purely combinational view mux; no extra latency over the registers.
    assign io_out = view ? cand_q : {state_q, 6'b000000};

endmodule

// File: tb/tb_blueintegral_mat_factor.sv
// ---------------------------------------------------------------------------
// tb_blueintegral_mat_factor
//
// Drives blueintegral_mat_factor through its pin map and compares its
// results against a matrix-arithmetic reference that finds the first
// factorising pair by brute force over all 256 candidates.
// ---------------------------------------------------------------------------
module tb_blueintegral_mat_factor;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] cmd;
    logic [3:0] data;
    wire  [7:0] ioIn;
    wire  [7:0] ioOut;

    int testsRun = 0;
    int testsFailed = 0;

    assign ioIn = {data, cmd, rstN, clk};

    blueintegral_mat_factor dut (
        .io_in  (ioIn),
        .io_out (ioOut)
    );

    // Free-running clock on pin 0.
    always #5 clk = ~clk;

    // Absolute time limit so the bench never hangs.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Product of candidate n computed as ordinary integer matrix algebra,
    // returned in the packed pin format {C00,C01,C10,C11}.
    function automatic int productOf(input int n);
        int a [2][2];
        int b [2][2];
        int c [2][2];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                a[i][j] = (n >> (7 - (2 * i + j))) & 1;
                b[i][j] = (n >> (3 - (2 * i + j))) & 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c[i][j] = 0;
                for (int k = 0; k < 2; k++) c[i][j] += a[i][k] * b[k][j];
            end
        end
        return c[0][0] * 64 + c[0][1] * 16 + c[1][0] * 4 + c[1][1];
    endfunction

    // First candidate whose product equals the target, or -1 if none does.
    function automatic int firstMatch(input int t);
        for (int n = 0; n < 256; n++) begin
            if (productOf(n) == t) return n;
        end
        return -1;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [3:0] d);
        cmd  = c;
        data = d;
    endtask

    // Read both views combinationally (view select is data[0]).
    task automatic readViews(output logic [7:0] statusView, output logic [7:0] candView);
        data = 4'h0;
        #1 statusView = ioOut;
        data = 4'h1;
        #1 candView = ioOut;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic loadTarget(input logic [7:0] t);
        applyStimulus(2'b01, t[3:0]);
        tick();
        applyStimulus(2'b10, t[7:4]);
        tick();
        applyStimulus(2'b00, 4'h0);
    endtask

    // Load, start, and follow the scan until it leaves SEARCH; checks the
    // terminal status, the reported candidate and the cycle count.
    task automatic runSearch(input string tag, input logic [7:0] t,
                             output logic [7:0] candOut);
        logic [7:0] sv, cv;
        int         n, expCycles, cycles;
        logic [7:0] expStatus, expCand;
        n         = firstMatch(int'(t));
        expCycles = (n >= 0) ? n + 1 : 256;
        expStatus = (n >= 0) ? 8'h80 : 8'hC0;
        expCand   = (n >= 0) ? 8'(n) : 8'hFF;
        loadTarget(t);
        readViews(sv, cv);
        checkOutput({tag, "_idle"}, sv, 8'h00);
        applyStimulus(2'b11, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        readViews(sv, cv);
        checkOutput({tag, "_search"}, sv, 8'h40);
        cycles = 0;
        while (sv == 8'h40 && cycles < 300) begin
            tick();
            cycles++;
            readViews(sv, cv);
        end
        checkOutput({tag, "_cycles"}, cycles, expCycles);
        checkOutput({tag, "_status"}, sv, expStatus);
        checkOutput({tag, "_cand"}, cv, expCand);
        candOut = cv;
    endtask

    initial begin
        logic [7:0] sv, cv, cand;
        logic [7:0] t;

        // Reset with a start command pending: reset wins.
        rstN = 1'b0;
        applyStimulus(2'b11, 4'h0);
        tick();
        tick();
        rstN = 1'b1;
        applyStimulus(2'b00, 4'h0);
        readViews(sv, cv);
        checkOutput("reset_status", sv, 8'h00);
        checkOutput("reset_cand", cv, 8'h00);

        // Zero target matches the very first candidate.
        runSearch("zero", 8'h00, cand);

        // Identity: first factorisation is swap*swap.
        runSearch("ident", 8'h41, cand);
        checkOutput("ident_swap", cand, 8'h66);

        // C00=2 needs both A00*B00 and A01*B10.
        runSearch("c00two", 8'h80, cand);
        checkOutput("c00two_cand", cand, 8'hCA);

        // An entry of 3 is unreachable; full 256-cycle scan ends in NONE.
        runSearch("three", 8'hC0, cand);

        // Idle hold: nops after NONE keep everything.
        tick();
        tick();
        readViews(sv, cv);
        checkOutput("hold_status", sv, 8'hC0);
        checkOutput("hold_cand", cv, 8'hFF);

        // Load mid-search returns to IDLE and keeps the candidate.
        applyStimulus(2'b11, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        repeat (32) tick();
        readViews(sv, cv);
        checkOutput("mid_cand", cv, 8'h20);
        applyStimulus(2'b01, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        tick();
        readViews(sv, cv);
        checkOutput("mid_load_status", sv, 8'h00);
        checkOutput("mid_load_cand", cv, 8'h20);
        applyStimulus(2'b11, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        readViews(sv, cv);
        checkOutput("restart_status", sv, 8'h40);
        checkOutput("restart_cand", cv, 8'h00);
        tick();
        readViews(sv, cv);
        checkOutput("restart_step", cv, 8'h01);

        // Restart during SEARCH via a second start.
        repeat (5) tick();
        applyStimulus(2'b11, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        readViews(sv, cv);
        checkOutput("restart2_cand", cv, 8'h00);

        // Reset during SEARCH, then confirm T was cleared.
        repeat (10) tick();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        readViews(sv, cv);
        checkOutput("rst_search_status", sv, 8'h00);
        checkOutput("rst_search_cand", cv, 8'h00);
        repeat (3) tick();
        readViews(sv, cv);
        checkOutput("rst_no_resume", {sv, cv}, 16'h0000);
        applyStimulus(2'b11, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        tick();
        readViews(sv, cv);
        checkOutput("rst_t_cleared", sv, 8'h80);

        // Reset together with start during SEARCH.
        loadTarget(8'hC0);
        applyStimulus(2'b11, 4'h0);
        tick();
        applyStimulus(2'b00, 4'h0);
        repeat (7) tick();
        rstN = 1'b0;
        applyStimulus(2'b11, 4'h0);
        tick();
        rstN = 1'b1;
        applyStimulus(2'b00, 4'h0);
        readViews(sv, cv);
        checkOutput("rst_start_status", sv, 8'h00);
        checkOutput("rst_start_cand", cv, 8'h00);
        tick();
        readViews(sv, cv);
        checkOutput("rst_start_idle", {sv, cv}, 16'h0000);

        // Randomized targets: half are products of a random candidate so
        // they are guaranteed reachable, half are arbitrary bytes.
        for (int r = 0; r < 8; r++) begin
            if (r % 2 == 0) t = 8'(productOf(int'($urandom_range(255))));
            else            t = 8'($urandom_range(255));
            runSearch($sformatf("rand%0d_%02h", r, t), t, cand);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
